// File: rtl/sorter_pkg.sv
// ============================================================================
// Module      : sorter_pkg
// Description : Shared defaults, sort-direction constants and tx state
//               encoding for the sorted stream transmitter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package sorter_pkg;

    localparam int SORT_N = 8;
    localparam int SORT_W = 4;

    localparam logic DIR_ASC  = 1'b1;
    localparam logic DIR_DESC = 1'b0;

    typedef enum logic [0:0] {
        TX_IDLE = 1'b0,
        TX_SEND = 1'b1
    } tx_state_e;

endpackage

`default_nettype wire

// File: rtl/order_check.sv
// ============================================================================
// Module      : order_check
// Description : Combinational adjacent-pair order checker; err is set when any
//               neighbour pair breaks the requested direction (unsigned).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module order_check
    import sorter_pkg::*;
#(
    parameter int N = SORT_N,
    parameter int W = SORT_W
) (
    input  logic [N*W-1:0] frame,
    input  logic           dir,
    output logic           err
);

    logic [N-2:0] w_bad;

    // Equal neighbours are legal in either direction, hence strict compares.
    for (genvar i = 0; i < N - 1; i++) begin : g_cmp
        logic [W-1:0] w_a;
        logic [W-1:0] w_b;
        assign w_a      = frame[W*i +: W];
        assign w_b      = frame[W*(i+1) +: W];
        assign w_bad[i] = (dir == DIR_ASC) ? (w_a > w_b) : (w_a < w_b);
    end

    assign err = |w_bad;

endmodule

`default_nettype wire

// File: rtl/sorted_stream_tx.sv
// ============================================================================
// Module      : sorted_stream_tx
// Description : Captures a parallel sorted frame and streams it out one element
//               per handshake. Optional order check: SORTED_STREAM_TX_ORDER_CHECK_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sorted_stream_tx
    import sorter_pkg::*;
#(
    parameter int N = SORT_N,
    parameter int W = SORT_W
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [N*W-1:0]       in_data,
    input  logic                 in_dir,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [W-1:0]         out_data,
    output logic [$clog2(N)-1:0] out_idx,
    output logic                 out_last,
    output logic                 order_err,
    output logic                 busy
);

    localparam int             IW         = $clog2(N);
    localparam logic [0:0]     c_ST_IDLE  = TX_IDLE;
    localparam logic [0:0]     c_ST_SEND  = TX_SEND;
    localparam logic [IW-1:0]  c_LAST_IDX = IW'(N - 1);
    localparam logic [IW-1:0]  c_IDX_ONE  = IW'(1);

    logic [0:0]     r_state;
    logic [N*W-1:0] r_frame;
    logic [IW-1:0]  r_idx;
    logic           r_err;

    logic           w_accept;
    logic           w_beat;
    logic           w_err;
    logic [W-1:0]   w_elem [N];

`ifdef SORTED_STREAM_TX_ORDER_CHECK_EN
    order_check #(
        .N (N),
        .W (W)
    ) u_order_check (
        .frame (in_data),
        .dir   (in_dir),
        .err   (w_err)
    );
`else
    // Direction only matters to the checker; here it folds to a constant zero.
    assign w_err = in_dir & ~in_dir;
`endif

    assign in_ready  = (r_state == c_ST_IDLE);
    assign out_valid = (r_state == c_ST_SEND);
    assign busy      = (r_state == c_ST_SEND);
    assign w_accept  = in_valid && in_ready;
    assign w_beat    = out_valid && out_ready;

    for (genvar i = 0; i < N; i++) begin : g_elem
        assign w_elem[i] = r_frame[W*i +: W];
    end

    assign out_data  = w_elem[r_idx];
    assign out_idx   = r_idx;
    assign out_last  = out_valid && (r_idx == c_LAST_IDX);
    assign order_err = r_err;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
            r_frame <= '0;
            r_idx   <= '0;
            r_err   <= 1'b0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (w_accept) begin
                        r_state <= c_ST_SEND;
                        r_frame <= in_data;
                        r_idx   <= '0;
                        r_err   <= w_err;
                    end
                end
                c_ST_SEND: begin
                    if (w_beat) begin
                        if (r_idx == c_LAST_IDX) begin
                            r_state <= c_ST_IDLE;
                            r_idx   <= '0;
                        end else begin
                            r_idx <= r_idx + c_IDX_ONE;
                        end
                    end
                end
                default: begin
                    r_state <= c_ST_IDLE;
                    r_idx   <= '0;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_sorted_stream_tx.sv
// ============================================================================
// Module      : tb_sorted_stream_tx
// Description : Self-checking bench for sorted_stream_tx with a frame-level
//               reference model; honours SORTED_STREAM_TX_ORDER_CHECK_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sorted_stream_tx;

    localparam int N  = 8;
    localparam int W  = 4;
    localparam int IW = 3;

`ifdef SORTED_STREAM_TX_ORDER_CHECK_EN
    localparam logic [31:0] EXP_ERR = 32'd1;
`else
    localparam logic [31:0] EXP_ERR = 32'd0;
`endif

    localparam logic [N*W-1:0] F_ASC  = 32'hFA97_5221;
    localparam logic [N*W-1:0] F_DESC = 32'h0123_88CF;
    localparam logic [N*W-1:0] F_BAD  = 32'h7654_9321;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           in_valid = 1'b0;
    logic           in_ready;
    logic [N*W-1:0] in_data = '0;
    logic           in_dir = 1'b1;
    logic           out_valid;
    logic           out_ready = 1'b0;
    logic [W-1:0]   out_data;
    logic [IW-1:0]  out_idx;
    logic           out_last;
    logic           order_err;
    logic           busy;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    bit chk_en = 1'b0;

    logic [W-1:0] beats[$];
    logic         lasts[$];
    int           acc[$];

    sorted_stream_tx #(.N(N), .W(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_dir    (in_dir),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_idx   (out_idx),
        .out_last  (out_last),
        .order_err (order_err),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: a frame is a list of elements still owed to the sink.
    function automatic bit frame_bad(input logic [N*W-1:0] f, input logic d);
        bit bad = 1'b0;
`ifdef SORTED_STREAM_TX_ORDER_CHECK_EN
        for (int i = 0; i < N - 1; i++) begin
            int a = int'(f[W*i +: W]);
            int b = int'(f[W*(i+1) +: W]);
            if (d && a > b) bad = 1'b1;
            if (!d && a < b) bad = 1'b1;
        end
`endif
        return bad;
    endfunction

    logic [W-1:0] m_pend[$];
    int           m_sent = 0;
    bit           m_err  = 1'b0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst) begin
            m_pend.delete();
            m_sent <= 0;
            m_err  <= 1'b0;
        end else if (m_pend.size() == 0) begin
            if (in_valid) begin
                for (int i = 0; i < N; i++) m_pend.push_back(in_data[W*i +: W]);
                m_sent <= 0;
                m_err  <= frame_bad(in_data, in_dir);
            end
        end else if (out_ready) begin
            void'(m_pend.pop_front());
            m_sent <= (m_pend.size() == 0) ? 0 : m_sent + 1;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("in_ready", {31'd0, in_ready}, {31'd0, m_pend.size() == 0});
            chk("out_valid", {31'd0, out_valid}, {31'd0, m_pend.size() != 0});
            chk("busy", {31'd0, busy}, {31'd0, m_pend.size() != 0});
            chk("order_err", {31'd0, order_err}, {31'd0, m_err});
            if (m_pend.size() != 0) begin
                chk("out_idx", {29'd0, out_idx}, 32'(m_sent));
                chk("out_data", {28'd0, out_data}, {28'd0, m_pend[0]});
                chk("out_last", {31'd0, out_last}, {31'd0, m_pend.size() == 1});
            end else begin
                chk("idle_idx", {29'd0, out_idx}, 32'd0);
                chk("idle_last", {31'd0, out_last}, 32'd0);
            end
        end
        if (!rst && out_valid && out_ready) begin
            beats.push_back(out_data);
            lasts.push_back(out_last);
        end
        if (!rst && in_valid && in_ready) acc.push_back(cyc);
    end

    task automatic wait_idle(output int k);
        k = 0;
        while (!in_ready && k < 200) begin
            @(posedge clk); #1;
            k++;
        end
        if (k >= 200) chk("idle_timeout", 32'd0, 32'd1);
    endtask

    task automatic send(input logic [N*W-1:0] f, input logic d);
        int k;
        wait_idle(k);
        in_valid = 1'b1;
        in_data  = f;
        in_dir   = d;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic check_beats(input string name, input logic [N*W-1:0] f, input int start);
        if (beats.size() < start + N) begin
            chk({name, "_count"}, 32'(beats.size()), 32'(start + N));
        end else begin
            for (int i = 0; i < N; i++)
                chk(name, {28'd0, beats[start+i]}, {28'd0, f[W*i +: W]});
        end
    endtask

    initial begin
        int k;
        logic [N*W-1:0] f;
        logic [W-1:0]   v;

        @(posedge clk); #1;
        chk_en = 1'b1;
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_data", {28'd0, out_data}, 32'd0);
        chk("rst_out_idx", {29'd0, out_idx}, 32'd0);
        chk("rst_out_last", {31'd0, out_last}, 32'd0);
        chk("rst_order_err", {31'd0, order_err}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        out_ready = 1'b1;

        // Ascending frame at full throughput.
        beats.delete(); lasts.delete();
        send(F_ASC, 1'b1);
        chk("asc_first_valid", {31'd0, out_valid}, 32'd1);
        chk("asc_first_data", {28'd0, out_data}, 32'h1);
        wait_idle(k);
        chk("asc_len", 32'(k), 32'd8);
        check_beats("asc_beat", F_ASC, 0);
        if (lasts.size() == N)
            for (int i = 0; i < N; i++)
                chk("asc_last", {31'd0, lasts[i]}, {31'd0, i == N - 1});
        chk("asc_err", {31'd0, order_err}, 32'd0);

        // Descending frame with alternating backpressure.
        beats.delete();
        send(F_DESC, 1'b0);
        out_ready = 1'b1;
        k = 0;
        while (!in_ready && k < 100) begin
            @(posedge clk); #1;
            k++;
            out_ready = !out_ready;
        end
        out_ready = 1'b1;
        chk("desc_len", 32'(k), 32'd15);
        check_beats("desc_beat", F_DESC, 0);
        chk("desc_err", {31'd0, order_err}, 32'd0);

        // Out-of-order frame still flows; flag persists into IDLE.
        beats.delete();
        send(F_BAD, 1'b1);
        chk("bad_err_capture", {31'd0, order_err}, EXP_ERR);
        wait_idle(k);
        chk("bad_err_hold", {31'd0, order_err}, EXP_ERR);
        check_beats("bad_beat", F_BAD, 0);
        send(F_ASC, 1'b1);
        chk("bad_err_clear", {31'd0, order_err}, 32'd0);
        wait_idle(k);

        // Reset in mid-frame.
        send(F_BAD, 1'b1);
        k = 0;
        while (out_idx != 3'd3 && k < 20) begin
            @(posedge clk); #1;
            k++;
        end
        chk("mid_idx3", {29'd0, out_idx}, 32'd3);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("mid_rst_valid", {31'd0, out_valid}, 32'd0);
        chk("mid_rst_ready", {31'd0, in_ready}, 32'd1);
        chk("mid_rst_err", {31'd0, order_err}, 32'd0);
        beats.delete();
        repeat (3) @(posedge clk);
        #1;
        chk("mid_rst_quiet", 32'(beats.size()), 32'd0);
        send(F_DESC, 1'b0);
        chk("mid_restart_idx", {29'd0, out_idx}, 32'd0);
        wait_idle(k);
        check_beats("mid_restart_beat", F_DESC, 0);

        // Back-to-back frames with in_valid held; input changes mid-SEND.
        beats.delete(); acc.delete();
        in_valid = 1'b1;
        in_data  = F_ASC;
        in_dir   = 1'b1;
        @(posedge clk); #1;
        in_data  = F_DESC;
        in_dir   = 1'b0;
        k = 0;
        while (acc.size() < 2 && k < 50) begin
            @(posedge clk); #1;
            k++;
        end
        in_valid = 1'b0;
        if (acc.size() >= 2) chk("b2b_period", 32'(acc[1] - acc[0]), 32'(N + 1));
        else chk("b2b_count", 32'(acc.size()), 32'd2);
        wait_idle(k);
        check_beats("b2b_first", F_ASC, 0);
        check_beats("b2b_second", F_DESC, N);

        // Randomised traffic, sorted and unsorted frames, occasional reset.
        for (int c = 0; c < 1500; c++) begin
            @(posedge clk); #1;
            rst       = ($urandom_range(0, 99) == 0);
            in_valid  = ($urandom_range(0, 2) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 1) == 1) begin
                v = W'($urandom_range(0, 3));
                in_dir = $urandom_range(0, 1);
                for (int i = 0; i < N; i++) begin
                    f[W*i +: W] = v;
                    if (v < 4'hE) v = v + W'($urandom_range(0, 2));
                end
                if (!in_dir)
                    for (int i = 0; i < N; i++) in_data[W*i +: W] = f[W*(N-1-i) +: W];
                else
                    in_data = f;
            end else begin
                in_data = $urandom;
                in_dir  = $urandom_range(0, 1);
            end
        end
        rst = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        wait_idle(k);
        repeat (2) @(posedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/sorted_stream_tx.md
SORTED_STREAM_TX -- requirements
Module: sorted_stream_tx

Interface
REQ-001 Parameter N, default 8: elements per frame; power of two, 2..16.
REQ-002 Parameter W, default 4: element width in bits.
REQ-003 Clock and reset: one clock; reset is synchronous and active-high.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 in_valid  input  1  parallel sorted frame present on in_data.
REQ-007 in_ready  output  1  block can accept a frame; high only in IDLE.
REQ-008 in_data  input  N*W  frame; element i at bits [W*i+W-1 : W*i].
REQ-009 in_dir  input  1  sort direction of frame: 1 ascending, 0 descending.
REQ-010 out_valid  output  1  out_data holds a valid element.
REQ-011 out_ready  input  1  downstream accepts element.
REQ-012 out_data  output  W  current element.
REQ-013 out_idx  output  log2(N)  index of current element.
REQ-014 out_last  output  1  current element is index N-1.
REQ-015 order_err  output  1  captured frame violated in_dir ordering.
REQ-016 busy  output  1  frame held and not fully transmitted.

Function
REQ-017 States IDLE and SEND only; IDLE->SEND on in_valid && in_ready; SEND->IDLE on out_valid && out_ready && out_last.
REQ-018 Capture: in_data and in_dir register on accepting edge; in_data changes afterward have no effect.
REQ-019 Latency: frame accepted at edge T gives out_valid=1, out_idx=0 from after edge T, i.e. first element is visible in the cycle following acceptance.
REQ-020 Element advance: each out_valid && out_ready edge increments out_idx by 1; out_data = captured element out_idx.
REQ-021 Stall: while out_valid && !out_ready, out_data, out_idx, out_last hold stable.
REQ-022 Throughput: with out_ready held high, N consecutive elements on N cycles, then one IDLE cycle; frame period N+1 cycles.
REQ-023 in_ready is combinational from state only (IDLE), never from out_ready; no same-cycle frame overlap.
REQ-024 out_idx wraps to 0 on return to IDLE; out_valid=0 in IDLE.
REQ-025 busy equals (state == SEND).
REQ-026 Order rule: ascending requires e[i] <= e[i+1], descending requires e[i] >= e[i+1], for all i in 0..N-2; equal neighbours never flag an error; unsigned compare.
REQ-027 order_err registers at capture edge, holds through SEND and following IDLE until next capture.
REQ-028 Errored frames still transmit unchanged; no element dropped or reordered.

Reset
REQ-029 rst forces IDLE: in_ready=1, out_valid=0, out_data=0, out_idx=0, out_last=0, order_err=0, busy=0 after the edge.
REQ-030 rst mid-frame discards remaining elements; no further out_valid until a new frame is accepted.
REQ-031 rst has priority over simultaneous in_valid or out_ready.

Configuration
REQ-032 Macro SORTED_STREAM_TX_ORDER_CHECK_EN defined: order check per REQ-026/027 compiled in.
REQ-033 Macro undefined: no comparators synthesized; order_err tied 0; all other behaviour identical.

Structure
REQ-034 Shared package sorter_pkg holds SORT_N, SORT_W defaults, direction constants DIR_ASC=1/DIR_DESC=0, and the tx state enum.
REQ-035 One sub-module order_check: combinational, N-1 adjacent comparators, inputs frame and dir, output err; instantiated only under the macro.

Verification
REQ-036 Ascending frame elements 0..7 = 1,2,2,5,7,9,A,F, dir=1, out_ready=1 -> 8 beats 1,2,2,5,7,9,A,F, out_last on beat 8 only, order_err=0, in_ready back high next cycle.
REQ-037 Descending F,C,8,8,3,2,1,0, dir=0, out_ready toggled 1,0,1,0 -> each element held stable during stalls, order 0..7 preserved, order_err=0.
REQ-038 Ascending frame 1,2,3,9,4,5,6,7, dir=1 -> order_err=1 from capture edge; all 8 elements still sent unchanged; next valid frame clears order_err.
REQ-039 Assert rst while out_idx=3 -> next cycle out_valid=0, in_ready=1, order_err=0; new frame restarts at out_idx=0.
REQ-040 in_valid held high for two frames, out_ready=1 -> second frame accepted exactly N+1 cycles after first; in_data change mid-SEND does not alter outputs.
REQ-041 Macro undefined, violating frame from REQ-038 -> order_err stays 0, data stream identical.
